// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding and hazard control for a 5-stage in-order pipeline.
// The block keeps its own shadow copies of the EX and MEM stage destination
// information. From them it registers the EX operand-mux selects, raises a
// one-cycle load-use stall, and turns a taken branch into a flush. It also
// counts stall and flush events in saturating counters.
//
// There is no valid/ready handshake. stall and flush are combinational
// commands to the surrounding pipeline. The pipeline must obey them in the
// same cycle: hold IF/ID on stall, and squash IF/ID and ID/EX on flush.
module fwd_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,
    input  logic             cnt_clear,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_MEMWB = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;

    // Shadow EX record
    logic       ex_valid_q, ex_valid_d;
    logic [4:0] ex_rd_q, ex_rd_d;
    logic       ex_reg_write_q, ex_reg_write_d;
    logic       ex_mem_read_q, ex_mem_read_d;

    // Shadow MEM record
    logic       mem_valid_q, mem_valid_d;
    logic [4:0] mem_rd_q, mem_rd_d;
    logic       mem_reg_write_q, mem_reg_write_d;
    logic       mem_mem_read_q, mem_mem_read_d;

    // Registered forwarding selects and event counters
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Hazard decode
    logic match_ex_a, match_ex_b;
    logic match_mem_a, match_mem_b;
    logic load_use;
    logic stall_int;
    logic flush_int;
    logic bubble_in;

    // Source matching against the shadow producers. Writes to x0 never count.
    always_comb begin
        match_ex_a  = ex_valid_q && ex_reg_write_q && (ex_rd_q != 5'd0)
                      && (ex_rd_q == id_rs1) && id_use_rs1;
        match_ex_b  = ex_valid_q && ex_reg_write_q && (ex_rd_q != 5'd0)
                      && (ex_rd_q == id_rs2) && id_use_rs2;
        match_mem_a = mem_valid_q && mem_reg_write_q && (mem_rd_q != 5'd0)
                      && (mem_rd_q == id_rs1) && id_use_rs1;
        match_mem_b = mem_valid_q && mem_reg_write_q && (mem_rd_q != 5'd0)
                      && (mem_rd_q == id_rs2) && id_use_rs2;
    end

    // Stall/flush decision. A flush wins over a stall, and reset masks both.
    always_comb begin
        load_use  = id_valid && ex_mem_read_q && (match_ex_a || match_ex_b);
        flush_int = rst && ex_branch_taken;
        stall_int = rst && load_use && !ex_branch_taken;
        bubble_in = !id_valid || stall_int || flush_int;
        stall     = stall_int;
        flush     = flush_int;
    end

    // Next state: shift the records and pick the selects for the instruction now entering EX.
    always_comb begin
        ex_valid_d      = !bubble_in;
        ex_rd_d         = bubble_in ? 5'd0 : id_rd;
        ex_reg_write_d  = bubble_in ? 1'b0 : id_reg_write;
        ex_mem_read_d   = bubble_in ? 1'b0 : id_mem_read;

        mem_valid_d     = ex_valid_q;
        mem_rd_d        = ex_rd_q;
        mem_reg_write_d = ex_reg_write_q;
        mem_mem_read_d  = ex_mem_read_q;

        // The youngest producer (EX) takes priority over MEM.
        fwd_a_d = SEL_RF;
        fwd_b_d = SEL_RF;
        if (!bubble_in) begin
            if (match_ex_a)       fwd_a_d = SEL_EXMEM;
            else if (match_mem_a) fwd_a_d = SEL_MEMWB;
            if (match_ex_b)       fwd_b_d = SEL_EXMEM;
            else if (match_mem_b) fwd_b_d = SEL_MEMWB;
        end
    end

    // Saturating event counters. A clear beats an increment in the same cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clear) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_int && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_int && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q      <= 1'b0;
            ex_rd_q         <= 5'd0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_rd_q        <= 5'd0;
            mem_reg_write_q <= 1'b0;
            mem_mem_read_q  <= 1'b0;
            fwd_a_q         <= SEL_RF;
            fwd_b_q         <= SEL_RF;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_rd_q         <= ex_rd_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_valid_q     <= mem_valid_d;
            mem_rd_q        <= mem_rd_d;
            mem_reg_write_q <= mem_reg_write_d;
            mem_mem_read_q  <= mem_mem_read_d;
            fwd_a_q         <= fwd_a_d;
            fwd_b_q         <= fwd_b_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl. A second instance with 2-bit
// counters shares the same stimulus so that saturation can be observed.
module tb_fwd_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic        id_reg_write, id_mem_read;
    logic        ex_branch_taken;
    logic        cnt_clear;

    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall, flush;
    logic [15:0] stall_cnt, flush_cnt;

    logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
    logic        s_stall, s_flush;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    // scoreboard: expected {fwd_a_sel, fwd_b_sel} per instruction slot entering EX
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_sel;
    logic        obs_stall, obs_flush;
    int          n_chk;
    int          n_err;
    logic [15:0] exp_stall_cnt;
    logic [15:0] exp_flush_cnt;

    fwd_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .cnt_clear(cnt_clear),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .flush(flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    fwd_hazard_ctrl #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .cnt_clear(cnt_clear),
        .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
        .stall(s_stall), .flush(s_flush),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver: present one ID slot for a cycle, record the comb outputs at the
    // falling edge, push the selects this slot should register on entering EX
    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic br,
                         input logic [3:0] exp_s);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; ex_branch_taken = br;
        exp_q.push_back(exp_s);
        @(negedge clk);
        obs_stall = stall;
        obs_flush = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic bubbles();
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
            exp_sel = exp_q.pop_front();
            n_chk++;
            if ({fwd_a_sel, fwd_b_sel} !== exp_sel) begin
                n_err++;
                $display("FAIL bubble_sel got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, exp_sel);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd5; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        id_rd = 5'd5; id_reg_write = 1'b1; id_mem_read = 1'b1;
        ex_branch_taken = 1'b1; cnt_clear = 1'b0;
        #1 rst = 1'b0;
        #2;
        n_chk++;
        if ({fwd_a_sel, fwd_b_sel, stall, flush} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outs got=%b exp=000000", {fwd_a_sel, fwd_b_sel, stall, flush});
        end
        n_chk++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cnts got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (flush !== 1'b0 || flush_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_flush_masked flush=%b cnt=%0d exp=0/0", flush, flush_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        id_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ex_mem_fwd();
        bubbles();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0000); // add x5,x1,x2
        exp_sel = exp_q.pop_front();
        n_chk++;
        if ({fwd_a_sel, fwd_b_sel} !== exp_sel) begin
            n_err++;
            $display("FAIL exmem_producer_sel got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, exp_sel);
        end
        issue(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 4'b1000); // sub x6,x5,x1
        exp_sel = exp_q.pop_front();
        n_chk++;
        if ({fwd_a_sel, fwd_b_sel} !== exp_sel) begin
            n_err++;
            $display("FAIL exmem_consumer_sel got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, exp_sel);
        end
        n_chk++;
        if (obs_stall !== 1'b0) begin
            n_err++;
            $display("FAIL exmem_no_stall got=%b exp=0", obs_stall);
        end
    endtask

    task automatic test_double_producer();
        bubbles();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0000); // add x5
        void'(exp_q.pop_front());
        issue(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0000); // add x5
        exp_sel = exp_q.pop_front();
        n_chk++;
        if ({fwd_a_sel, fwd_b_sel} !== exp_sel) begin
            n_err++;
            $display("FAIL double_mid_sel got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, exp_sel);
        end
        issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 4'b1010); // or x7,x5,x5
        exp_sel = exp_q.pop_front();
        n_chk++;
        if ({fwd_a_sel, fwd_b_sel} !== exp_sel) begin
            n_err++;
            $display("FAIL double_youngest_sel got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, exp_sel);
        end
        bubbles();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0000); // add x5
        void'(exp_q.pop_front());
        issue(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 4'b0000); // add x10
        void'(exp_q.pop_front());
        issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 4'b0101); // or x7,x5,x5
        exp_sel = exp_q.pop_front();
        n_chk++;
        if ({fwd_a_sel, fwd_b_sel} !== exp_sel) begin
            n_err++;
            $display("FAIL memwb_fwd_sel got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, exp_sel);
        end
    endtask

    task automatic test_load_use();
        bubbles();
        issue(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 4'b0000); // lw x8
        void'(exp_q.pop_front());
        issue(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 4'b0000); // add x9,x8,x2 (stalled)
        exp_stall_cnt++;
        exp_sel = exp_q.pop_front();
        n_chk++;
        if (obs_stall !== 1'b1) begin
            n_err++;
            $display("FAIL load_use_stall got=%b exp=1", obs_stall);
        end
        n_chk++;
        if ({fwd_a_sel, fwd_b_sel} !== exp_sel) begin
            n_err++;
            $display("FAIL load_use_bubble_sel got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, exp_sel);
        end
        n_chk++;
        if (stall_cnt !== exp_stall_cnt) begin
            n_err++;
            $display("FAIL load_use_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall_cnt);
        end
        issue(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 4'b0100); // held add
        exp_sel = exp_q.pop_front();
        n_chk++;
        if (obs_stall !== 1'b0) begin
            n_err++;
            $display("FAIL load_use_one_cycle got=%b exp=0", obs_stall);
        end
        n_chk++;
        if ({fwd_a_sel, fwd_b_sel} !== exp_sel) begin
            n_err++;
            $display("FAIL load_use_fwd_sel got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, exp_sel);
        end
        n_chk++;
        if (stall_cnt !== exp_stall_cnt) begin
            n_err++;
            $display("FAIL load_use_cnt_hold got=%0d exp=%0d", stall_cnt, exp_stall_cnt);
        end
    endtask

    task automatic test_x0_unused();
        bubbles();
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 4'b0000); // add x0
        void'(exp_q.pop_front());
        issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 4'b0000); // sub x6,x0,x0
        exp_sel = exp_q.pop_front();
        n_chk++;
        if ({fwd_a_sel, fwd_b_sel} !== exp_sel) begin
            n_err++;
            $display("FAIL x0_sel got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, exp_sel);
        end
        issue(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 4'b0000); // lw x0
        void'(exp_q.pop_front());
        issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd11, 1'b0, 1'b0, 1'b0, 4'b0000); // reads x0
        void'(exp_q.pop_front());
        n_chk++;
        if (obs_stall !== 1'b0) begin
            n_err++;
            $display("FAIL x0_load_no_stall got=%b exp=0", obs_stall);
        end
        issue(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 4'b0000); // lw x8
        void'(exp_q.pop_front());
        issue(1'b1, 5'd3, 5'd8, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 4'b0000); // rs2=x8 unused
        exp_sel = exp_q.pop_front();
        n_chk++;
        if (obs_stall !== 1'b0 || {fwd_a_sel, fwd_b_sel} !== exp_sel) begin
            n_err++;
            $display("FAIL unused_rs2 stall=%b sel=%b exp stall=0 sel=%b",
                     obs_stall, {fwd_a_sel, fwd_b_sel}, exp_sel);
        end
    endtask

    task automatic test_branch_during_load_use();
        bubbles();
        issue(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 4'b0000); // lw x8
        void'(exp_q.pop_front());
        issue(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 4'b0000); // add + taken branch
        exp_flush_cnt++;
        exp_sel = exp_q.pop_front();
        n_chk++;
        if (obs_flush !== 1'b1 || obs_stall !== 1'b0) begin
            n_err++;
            $display("FAIL branch_priority flush=%b stall=%b exp flush=1 stall=0", obs_flush, obs_stall);
        end
        n_chk++;
        if (flush_cnt !== exp_flush_cnt || stall_cnt !== exp_stall_cnt) begin
            n_err++;
            $display("FAIL branch_cnts flush_cnt=%0d stall_cnt=%0d exp %0d/%0d",
                     flush_cnt, stall_cnt, exp_flush_cnt, exp_stall_cnt);
        end
        n_chk++;
        if ({fwd_a_sel, fwd_b_sel} !== exp_sel) begin
            n_err++;
            $display("FAIL branch_bubble_sel got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, exp_sel);
        end
        // EX now holds a bubble and MEM holds the load: no stall and a MEM/WB forward
        issue(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 4'b0101);
        exp_sel = exp_q.pop_front();
        n_chk++;
        if (obs_stall !== 1'b0 || obs_flush !== 1'b0 || {fwd_a_sel, fwd_b_sel} !== exp_sel) begin
            n_err++;
            $display("FAIL branch_ex_bubble stall=%b flush=%b sel=%b exp 0/0/%b",
                     obs_stall, obs_flush, {fwd_a_sel, fwd_b_sel}, exp_sel);
        end
    endtask

    task automatic test_counter_bounds();
        bubbles();
        issue(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 4'b0000); // lw x8
        void'(exp_q.pop_front());
        cnt_clear = 1'b1;
        issue(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 4'b0000); // stall + clear
        cnt_clear = 1'b0;
        void'(exp_q.pop_front());
        exp_stall_cnt = 16'd0;
        exp_flush_cnt = 16'd0;
        n_chk++;
        if (obs_stall !== 1'b1 || stall_cnt !== 16'd0 || s_stall_cnt !== 2'd0 || flush_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL clear_vs_stall stall=%b cnt=%0d small=%0d fcnt=%0d exp 1/0/0/0",
                     obs_stall, stall_cnt, s_stall_cnt, flush_cnt);
        end
        issue(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 4'b0100);
        void'(exp_q.pop_front());
        for (int k = 0; k < 5; k++) begin
            issue(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 4'b0000);
            void'(exp_q.pop_front());
            issue(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 4'b0000);
            void'(exp_q.pop_front());
            exp_stall_cnt++;
            n_chk++;
            if (obs_stall !== 1'b1) begin
                n_err++;
                $display("FAIL repeat_stall iter=%0d got=%b exp=1", k, obs_stall);
            end
            issue(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 4'b0100);
            exp_sel = exp_q.pop_front();
            n_chk++;
            if ({fwd_a_sel, fwd_b_sel} !== exp_sel) begin
                n_err++;
                $display("FAIL repeat_fwd iter=%0d got=%b exp=%b", k, {fwd_a_sel, fwd_b_sel}, exp_sel);
            end
        end
        n_chk++;
        if (stall_cnt !== exp_stall_cnt) begin
            n_err++;
            $display("FAIL stall_cnt_wide got=%0d exp=%0d", stall_cnt, exp_stall_cnt);
        end
        n_chk++;
        if (s_stall_cnt !== 2'd3) begin
            n_err++;
            $display("FAIL stall_cnt_saturate got=%0d exp=3", s_stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        bubbles();
        issue(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 4'b0000); // lw x8
        void'(exp_q.pop_front());
        id_valid = 1'b1; id_rs1 = 5'd8; id_rs2 = 5'd2; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        id_rd = 5'd9; id_reg_write = 1'b1; id_mem_read = 1'b0; ex_branch_taken = 1'b0;
        @(negedge clk);
        n_chk++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_stall got=%b exp=1", stall);
        end
        #1 rst = 1'b0;
        #1;
        n_chk++;
        if ({fwd_a_sel, fwd_b_sel, stall, flush} !== 6'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL mid_stall_reset sel=%b%b stall=%b flush=%b cnts=%0d/%0d exp all 0",
                     fwd_a_sel, fwd_b_sel, stall, flush, stall_cnt, flush_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_no_stall got=%b exp=0", stall);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000 || stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL post_reset_enter sel=%b cnt=%0d exp 0000/0", {fwd_a_sel, fwd_b_sel}, stall_cnt);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_stall_cnt = 16'd0;
        exp_flush_cnt = 16'd0;
        test_reset();
        test_ex_mem_fwd();
        test_double_producer();
        test_load_use();
        test_x0_unused();
        test_branch_during_load_use();
        test_counter_bounds();
        test_reset_mid_stall();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall and flush event counters.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port id_valid, input, 1: a real instruction is present in ID.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, 5 each: source register numbers of the ID instruction.
REQ-006 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 each: ID instruction reads rs1/rs2.
REQ-007 SHALL have port id_rd, input, 5: destination register number of the ID instruction.
REQ-008 SHALL have ports id_reg_write and id_mem_read, input, 1 each: ID instruction writes rd / is a load.
REQ-009 SHALL have port ex_branch_taken, input, 1: the EX-stage branch/jump redirects the PC this cycle.
REQ-010 SHALL have port cnt_clear, input, 1: synchronous clear of both event counters.
REQ-011 SHALL have ports fwd_a_sel and fwd_b_sel, output, 2 each, registered: selects for the EX-stage 3-input operand forwarding muxes. Encoding: 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result.
REQ-012 SHALL have port stall, output, 1, combinational: hold PC and IF/ID, and insert a bubble into ID/EX.
REQ-013 SHALL have port flush, output, 1, combinational: squash IF/ID and ID/EX.
REQ-014 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each: saturating event counters.

Function
REQ-015 SHALL keep shadow stage records for EX and MEM, each holding {valid, rd, reg_write, mem_read}.
REQ-016 SHALL, on every clock edge, shift the ID record into EX and the EX record into MEM.
REQ-017 SHALL shift a bubble (valid=0) into the EX record instead of the ID record when stall=1 or flush=1.
REQ-018 SHALL treat a producer as matching a source only when all of the following hold: producer valid=1, reg_write=1, rd!=0, rd equals the source register, and the corresponding id_use_rsX=1.
REQ-019 SHALL, for each source, register the forwarding select on the edge the ID instruction moves into EX:
- 10 if it matches the EX record;
- else 01 if it matches the MEM record;
- else 00.
REQ-020 SHALL give the EX record priority over the MEM record when both match (youngest producer wins).
REQ-021 SHALL never produce select value 11.
REQ-022 SHALL register select 00 whenever a bubble enters EX.
REQ-023 SHALL assert stall when id_valid=1 and the EX record is a valid load (mem_read=1) that matches either used source of the ID instruction (load-use hazard).
REQ-024 SHALL limit a load-use stall to exactly 1 cycle. After the stall the load sits in the MEM record, and the dependent instruction enters EX with select 01.
REQ-025 SHALL assert flush whenever ex_branch_taken=1.
REQ-026 SHALL give flush priority over stall: when both conditions hold, stall=0 and flush=1.
REQ-027 SHALL NOT forward from WB-stage producers. The register file is write-before-read, which is outside this block's scope.
REQ-028 SHALL increment stall_cnt once per cycle with stall=1, and flush_cnt once per cycle with flush=1.
REQ-029 SHALL hold each counter at 2^CNT_W-1 once it saturates.
REQ-030 SHALL give cnt_clear priority over an increment in the same cycle, so the counter reads 0 on the next cycle.

Reset
REQ-031 SHALL, while rst=0, immediately set the following:
- both shadow records valid=0;
- fwd_a_sel=fwd_b_sel=00;
- stall_cnt=flush_cnt=0.
REQ-032 SHALL drive stall=0 and flush=0 while rst=0, regardless of inputs.
REQ-033 SHALL discard all in-flight hazard state on reset asserted mid-stall; the first post-reset cycle SHALL show no stall.

Verification
REQ-034 EX/MEM forward: add x5 followed by sub x6,x5,x1 -> sub enters EX with fwd_a_sel=10, fwd_b_sel=00, stall=0.
REQ-035 Double producer: add x5; add x5; or x7,x5,x5 -> or enters EX with fwd_a_sel=fwd_b_sel=10 (youngest wins). A single unrelated instruction between producer and consumer -> 01.
REQ-036 Load-use: lw x8; add x9,x8,x2 -> stall=1 for exactly 1 cycle, stall_cnt=1, add enters EX with fwd_a_sel=01.
REQ-037 x0 and unused source: producer rd=0, or consumer id_use_rs2=0 with a matching rs2 -> select 00, no stall.
REQ-038 Branch during load-use: ex_branch_taken=1 in the same cycle as the stall condition -> flush=1, stall=0, flush_cnt increments, EX record becomes a bubble.
REQ-039 Reset and counter boundaries:
- rst low mid-stall -> all outputs 0 at once;
- CNT_W=2 with 5 stalls -> stall_cnt=3;
- cnt_clear together with a stall -> 0.
